// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Common-data-bus arbiter for an out-of-order core. Each producer channel
//   owns a one-entry holding slot (full flag, tag, data). Every cycle in which
//   the bus is not stalled, one full slot is picked round-robin. Its tag and
//   data are broadcast on the registered cdb_* outputs, and the slot is freed.
//
// Configuration macro:
//   CDB_BACK_TO_BACK_EN  - when defined, a slot being granted this cycle also
//                          reports ready. It can reload on the same edge, so
//                          each channel sustains one result per cycle.
//                          When undefined, req_ready is a pure register
//                          output, and each channel peaks at one result every
//                          two cycles.
//
// Parameters:
//   NUM_CH  - number of producer channels (2..8)
//   DATA_W  - result data width
//   TAG_W   - reservation-station tag width
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_CH]         per-channel result offered
//   req_ready  out  [NUM_CH]         per-channel slot can accept
//   req_tag    in   [NUM_CH*TAG_W]   channel i at [i*TAG_W +: TAG_W]
//   req_data   in   [NUM_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//   cdb_stall  in   consumers not ready; bus, pointer and full flags hold
//   cdb_valid  out  broadcast present on the bus
//   cdb_tag    out  [TAG_W]  broadcast tag
//   cdb_data   out  [DATA_W] broadcast data
//   cdb_src    out  [SRC_W]  index of the winning channel
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
    parameter int TAG_W  = 3,
    localparam int SRC_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*TAG_W-1:0]  req_tag,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    input  logic                     cdb_stall,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [SRC_W-1:0]         cdb_src
);

    // Slot state
    logic [NUM_CH-1:0] full_q;
    logic [NUM_CH-1:0] full_d;
    logic [TAG_W-1:0]  tag_q  [NUM_CH];
    logic [DATA_W-1:0] data_q [NUM_CH];

    // Round-robin search start
    logic [SRC_W-1:0]  rr_ptr_q;
    logic [SRC_W-1:0]  rr_ptr_d;

    // Registered bus outputs
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [SRC_W-1:0]  cdb_src_q;

    // Arbitration results
    logic [NUM_CH-1:0] grant;
    logic              gnt_any;
    logic [SRC_W-1:0]  gnt_idx;
    logic [NUM_CH-1:0] accept;

    // Round-robin pick among full slots. The search starts at rr_ptr_q and
    // wraps modulo NUM_CH. NUM_CH need not be a power of two, so the wrap is
    // explicit. A stalled bus issues no grant at all.
    always_comb begin
        int idx;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!cdb_stall) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (!gnt_any && full_q[idx]) begin
                    gnt_any    = 1'b1;
                    gnt_idx    = SRC_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

`ifdef CDB_BACK_TO_BACK_EN
    // A slot draining this edge may refill on the same edge.
    assign req_ready = ~full_q | grant;
`else
    // Ready depends only on flop state, never on inputs.
    assign req_ready = ~full_q;
`endif

    assign accept = req_valid & req_ready;

    // An accept wins over a grant on the same slot. That overlap only occurs
    // in back-to-back mode, where the slot stays full with the new payload.
    always_comb begin
        full_d = full_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                full_d[i] = 1'b1;
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            if (gnt_idx == SRC_W'(NUM_CH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + SRC_W'(1);
            end
        end
    end

    // Control and bus state. With no grant, the bus keeps its last tag, data
    // and source. It drops valid only when the bus is not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            full_q   <= full_d;
            rr_ptr_q <= rr_ptr_d;
            if (gnt_any) begin
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= tag_q[gnt_idx];
                cdb_data_q  <= data_q[gnt_idx];
                cdb_src_q   <= gnt_idx;
            end else if (!cdb_stall) begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    // Slot payload. It is only read while its full flag is set, so it needs
    // no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
                data_q[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule
